conv_tile_mac_fp16: RTL and testbench
=====================================

Name: conv_tile_mac_fp16

Overview:
- Parametrised successor to the fixed 3x3-lane float16 convolution tile engine.
- Accumulates a PARA_X x PARA_Y output tile over K*K kernel taps and C input channels.
- Adds streaming valid/ready handshakes on both the input and output sides, a per-tile bias preload, an optional ReLU, and runtime kernel sizes 1..KERNEL_SIZE_MAX.
- Sits between the activation/weight fetch unit (upstream) and the output writeback buffer (downstream).

Parameters:
DATA_WIDTH, 16, float16 element width (fixed at 16; other values unsupported).
PARA_X, 3, number of output rows per tile.
PARA_Y, 3, number of output columns per tile.
KERNEL_SIZE_MAX, 7, largest legal runtime kernel size.
KS_WIDTH, 4, width of cfg_kernel_size.
CH_WIDTH, 10, width of cfg_channels.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-low reset.
cfg_start  in  1  one-cycle pulse that starts a tile; sampled only in IDLE.
cfg_kernel_size  in  KS_WIDTH  K, sampled on cfg_start.
cfg_channels  in  CH_WIDTH  C, sampled on cfg_start.
cfg_bias  in  16  float16 bias, sampled on cfg_start.
cfg_relu  in  1  1 = apply ReLU at output; sampled on cfg_start.
cfg_err  out  1  one-cycle pulse when cfg_start is rejected.
busy  out  1  high in every state except IDLE.
in_valid  in  1  upstream beat valid.
in_ready  out  1  high only in RUN.
in_data  in  PARA_X*PARA_Y*16  activations for one tap; lane i occupies bits [16i+15:16i].
in_weight  in  16  float16 weight for this tap, broadcast to all lanes.
out_valid  out  1  tile result valid.
out_ready  in  1  downstream accept.
out_data  out  PARA_X*PARA_Y*16  tile result; lane order matches in_data.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE; busy=0, in_ready=0, out_valid=0, cfg_err=0, out_data=0.
  - Accumulators and counters cleared.
  - Reset mid-operation abandons the tile; no partial result is emitted.
- States: IDLE, RUN, DONE.
- IDLE:
  - cfg_start with 1<=K<=KERNEL_SIZE_MAX and C>=1: latch K, C, bias and relu; every lane accumulator <= cfg_bias; tap_cnt=0, ch_cnt=0; go to RUN next cycle.
  - cfg_start with K=0, K>KERNEL_SIZE_MAX or C=0: cfg_err=1 for exactly one cycle; remain in IDLE.
- RUN:
  - in_ready=1. A beat is accepted when in_valid && in_ready.
  - Per accepted beat, every lane: acc <= fp16_add(acc, fp16_mul(lane, in_weight)). Registered, one beat per cycle, no bubbles required.
  - tap_cnt counts 0..K*K-1. On wrap it returns to 0 and ch_cnt increments.
  - The beat with tap_cnt=K*K-1 and ch_cnt=C-1 is the last; total beats = K*K*C.
  - After the last accepted beat: go to DONE. out_valid rises the next cycle, so latency is 1 cycle after the last handshake.
  - in_valid low stalls with no state change. cfg_start is ignored while busy (no cfg_err).
- DONE:
  - in_ready=0. out_valid=1; out_data = final accumulators, passed through ReLU when relu=1.
  - out_data is held stable while out_ready=0.
  - On out_valid && out_ready: out_valid=0, go to IDLE.
  - A cfg_start in the same cycle as the output handshake is ignored; the next tile starts at least one cycle later.
- Arithmetic:
  - IEEE-754 binary16, round-to-nearest-even.
  - Subnormal inputs and results are flushed to +0.
  - Overflow saturates to ±Inf. NaN propagates as 0x7E00.
- ReLU: any lane with sign bit set and not NaN outputs 0x0000 (-0.0 becomes 0x0000). NaN passes through unchanged.
- Counter widths: tap_cnt must hold KERNEL_SIZE_MAX^2-1; ch_cnt must hold 2^CH_WIDTH-1.

Test Plan:
- K=3, C=1, bias 0x0000, 9 beats with all lanes 1.0 (0x3C00) and weight 1.0 -> out_valid 1 cycle after 9th beat; every lane 0x4880 (9.0).
- K=3, C=2, bias 0x3C00, 18 beats with lanes 1.0 and weight 1.0, in_valid toggled 1-0 -> every lane 0x4CC0 (19.0); in_ready drops at DONE; result unaffected by stalls.
- K=1, C=1, bias -1.0 (0xBC00), lanes 0.5 (0x3800), weight 1.0: relu=0 -> 0xB800; relu=1 -> 0x0000.
- Hold out_ready low for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, cfg_start ignored; out_ready=1 -> IDLE next cycle, busy=0.
- cfg_start with K=0, then K=8, then C=0 -> three single-cycle cfg_err pulses; busy stays 0; no in_ready.
- rst asserted after 4 of 9 beats -> all outputs 0 immediately; a new K=3 tile then yields 0x4880, with no contamination from the abandoned tile.

Source files
------------

// File: rtl/conv_tile_mac_fp16.sv
// conv_tile_mac_fp16: float16 MAC engine for one PARA_X x PARA_Y output tile over K*K taps and C channels.
// Latency: one input beat per cycle in RUN; out_valid rises 1 cycle after the last input handshake.
// Backpressure: in_ready high only in RUN; in DONE out_data is held until out_ready, upstream stays stalled.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset (abandons any tile in flight)
//   cfg_start, cfg_*      tile configuration (K, C, bias, relu), sampled on cfg_start in IDLE only
//   cfg_err               one-cycle pulse when a cfg_start carries K=0, K>KERNEL_SIZE_MAX or C=0
//   busy                  high in RUN and DONE
//   in_valid/in_ready     one tap: PARA_X*PARA_Y float16 activations plus one broadcast weight
//   in_data, in_weight    lane i of in_data is bits [16i+15:16i]
//   out_valid/out_ready   tile result; out_data lane order matches in_data
module conv_tile_mac_fp16 #(
  parameter int DATA_WIDTH      = 16,
  parameter int PARA_X          = 3,
  parameter int PARA_Y          = 3,
  parameter int KERNEL_SIZE_MAX = 7,
  parameter int KS_WIDTH        = 4,
  parameter int CH_WIDTH        = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_start,
  input  logic [KS_WIDTH-1:0]                 cfg_kernel_size,
  input  logic [CH_WIDTH-1:0]                 cfg_channels,
  input  logic [DATA_WIDTH-1:0]               cfg_bias,
  input  logic                                cfg_relu,
  output logic                                cfg_err,
  output logic                                busy,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0]               in_weight,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0] out_data
);

  localparam int LANES = PARA_X * PARA_Y;
  localparam int TAPS  = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;
  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [15:0] QNAN = 16'h7E00;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef logic [LANES-1:0][DATA_WIDTH-1:0] lanes_t;

  // ---------------------------------------------------------------------------
  // binary16 arithmetic: RNE, subnormals flushed to +0, overflow to +-Inf,
  // every NaN result is the canonical quiet NaN.
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sr;
    logic [21:0] p;
    logic [10:0] m, rnd;
    logic        g, st, carry;
    int          e;
    logic [15:0] r;
    a_nan  = (a[14:10] == 5'h1f) && (a[9:0] != '0);
    b_nan  = (b[14:10] == 5'h1f) && (b[9:0] != '0);
    a_inf  = (a[14:10] == 5'h1f) && (a[9:0] == '0);
    b_inf  = (b[14:10] == 5'h1f) && (b[9:0] == '0);
    a_zero = (a[14:10] == 5'h00);
    b_zero = (b[14:10] == 5'h00);
    sr     = a[15] ^ b[15];
    p      = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    // Product of two 1.x mantissas lies in [1,4); normalise on bit 21.
    if (p[21]) begin
      m  = p[21:11];
      g  = p[10];
      st = |p[9:0];
      e  = int'(a[14:10]) + int'(b[14:10]) - 14;
    end else begin
      m  = p[20:10];
      g  = p[9];
      st = |p[8:0];
      e  = int'(a[14:10]) + int'(b[14:10]) - 15;
    end
    {carry, rnd} = {1'b0, m} + 12'(g && (st || m[0]));
    if (carry) e = e + 1;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) r = QNAN;
    else if (a_inf || b_inf)   r = {sr, 5'h1f, 10'h000};
    else if (a_zero || b_zero) r = {sr, 15'h0000};
    else if (e >= 31)          r = {sr, 5'h1f, 10'h000};
    else if (e <= 0)           r = 16'h0000;
    else                       r = {sr, 5'(e), carry ? rnd[10:1] : rnd[9:0]};
    return r;
  endfunction

  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [15:0] x, y, r;
    logic [40:0] sh;
    logic [13:0] mx, my;
    logic [14:0] s;
    logic [10:0] rnd;
    logic        carry, found;
    int          e, lz;
    a_nan  = (a[14:10] == 5'h1f) && (a[9:0] != '0);
    b_nan  = (b[14:10] == 5'h1f) && (b[9:0] != '0);
    a_inf  = (a[14:10] == 5'h1f) && (a[9:0] == '0);
    b_inf  = (b[14:10] == 5'h1f) && (b[9:0] == '0);
    a_zero = (a[14:10] == 5'h00);
    b_zero = (b[14:10] == 5'h00);
    r = '0; x = a; y = b; sh = '0; mx = '0; my = '0; s = '0;
    rnd = '0; carry = 1'b0; found = 1'b0; e = 0; lz = 0;
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) r = QNAN;
    else if (a_inf)             r = a;
    else if (b_inf)             r = b;
    else if (a_zero && b_zero)  r = {a[15] & b[15], 15'h0000};
    else if (a_zero)            r = b;
    else if (b_zero)            r = a;
    else begin
      if (a[14:0] < b[14:0]) begin
        x = b;
        y = a;
      end
      // 30 spare bits cover the largest exponent gap, so nothing is lost before
      // the bits below guard/round are folded into a single sticky bit.
      sh = {1'b1, y[9:0], 30'h0} >> (x[14:10] - y[14:10]);
      mx = {1'b1, x[9:0], 3'b000};
      my = {sh[40:28], |sh[27:0]};
      e  = int'(x[14:10]);
      if (x[15] == y[15]) s = {1'b0, mx} + {1'b0, my};
      else                s = {1'b0, mx} - {1'b0, my};
      if (s[14]) begin
        s = {1'b0, s[14:2], s[1] | s[0]};
        e = e + 1;
      end else begin
        for (int i = 13; i >= 0; i--) begin
          if (!found && s[i]) begin
            found = 1'b1;
            lz    = 13 - i;
          end
        end
        s = s << lz;
        e = e - lz;
      end
      {carry, rnd} = {1'b0, s[13:3]} + 12'(s[2] && (s[1] || s[0] || s[3]));
      if (carry) e = e + 1;
      if (s == '0)     r = 16'h0000;
      else if (e >= 31) r = {x[15], 5'h1f, 10'h000};
      else if (e <= 0)  r = 16'h0000;
      else              r = {x[15], 5'(e), carry ? rnd[10:1] : rnd[9:0]};
    end
    return r;
  endfunction

  // Negative values (including -0 and -Inf) clamp to +0; NaN passes through.
  function automatic logic [15:0] fp16_relu(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[15] && !((v[14:10] == 5'h1f) && (v[9:0] != '0))) r = 16'h0000;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                  state_q;
  logic [TAP_W-1:0]        tap_cnt_q, kk_m1_q;
  logic [CH_WIDTH-1:0]     ch_cnt_q, c_m1_q;
  logic                    relu_q;
  lanes_t                  acc_q, acc_d, res_d, out_data_q;
  logic                    busy_q, in_ready_q, out_valid_q, cfg_err_q;

  logic [2*KS_WIDTH-1:0]   kk_full;
  logic                    cfg_ok, beat_acc, last_tap, last_beat;

  assign kk_full   = (2*KS_WIDTH)'(cfg_kernel_size) * (2*KS_WIDTH)'(cfg_kernel_size);
  assign cfg_ok    = (cfg_kernel_size != '0) && (int'(cfg_kernel_size) <= KERNEL_SIZE_MAX) &&
                     (cfg_channels != '0);
  assign beat_acc  = in_valid && in_ready_q;
  assign last_tap  = (tap_cnt_q == kk_m1_q);
  assign last_beat = last_tap && (ch_cnt_q == c_m1_q);

  // Next accumulator value per lane and its output-stage (ReLU) view, so the
  // result register can be loaded on the same edge as the final beat.
  always_comb begin
    acc_d = acc_q;
    res_d = '0;
    for (int i = 0; i < LANES; i++) begin
      acc_d[i] = fp16_add(acc_q[i], fp16_mul(in_data[i*DATA_WIDTH +: DATA_WIDTH], in_weight));
      res_d[i] = relu_q ? fp16_relu(acc_d[i]) : acc_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      tap_cnt_q   <= '0;
      ch_cnt_q    <= '0;
      kk_m1_q     <= '0;
      c_m1_q      <= '0;
      relu_q      <= 1'b0;
      acc_q       <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg_start) begin
            if (cfg_ok) begin
              kk_m1_q    <= TAP_W'(kk_full - (2*KS_WIDTH)'(1));
              c_m1_q     <= cfg_channels - CH_WIDTH'(1);
              relu_q     <= cfg_relu;
              tap_cnt_q  <= '0;
              ch_cnt_q   <= '0;
              acc_q      <= {LANES{cfg_bias}};
              busy_q     <= 1'b1;
              in_ready_q <= 1'b1;
              state_q    <= S_RUN;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (beat_acc) begin
            acc_q <= acc_d;
            if (last_tap) begin
              tap_cnt_q <= '0;
              ch_cnt_q  <= ch_cnt_q + CH_WIDTH'(1);
            end else begin
              tap_cnt_q <= tap_cnt_q + TAP_W'(1);
            end
            if (last_beat) begin
              out_data_q  <= res_d;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              state_q     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cfg_err   = cfg_err_q;
  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_conv_tile_mac_fp16.sv
// tb_conv_tile_mac_fp16: directed bench for conv_tile_mac_fp16 with a result scoreboard.
// Expected tiles are queued when each tile is issued; a monitor pops one per output handshake.
// Control/handshake behaviour (reset, cfg_err, stalls, DONE hold) is checked inline.
module tb_conv_tile_mac_fp16;

  localparam int NL  = 9;
  localparam int DW  = 16;
  localparam int KSW = 4;
  localparam int CHW = 10;
  localparam int LW  = NL * DW;

  typedef logic [NL-1:0][DW-1:0] vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_start;
  logic [KSW-1:0] cfg_kernel_size;
  logic [CHW-1:0] cfg_channels;
  logic [DW-1:0]  cfg_bias;
  logic           cfg_relu;
  logic           cfg_err, busy;
  logic           in_valid, in_ready;
  logic [LW-1:0]  in_data;
  logic [DW-1:0]  in_weight;
  logic           out_valid, out_ready;
  logic [LW-1:0]  out_data;

  conv_tile_mac_fp16 dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_start       (cfg_start),
    .cfg_kernel_size (cfg_kernel_size),
    .cfg_channels    (cfg_channels),
    .cfg_bias        (cfg_bias),
    .cfg_relu        (cfg_relu),
    .cfg_err         (cfg_err),
    .busy            (busy),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_weight       (in_weight),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t exp_q[$];

  // Hand-computed vectors.
  localparam logic [15:0] HOLD_IN  [NL] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500,
                                            16'h4600, 16'h4700, 16'h4800, 16'h4880};
  // (1 + 2*x) for x = 1..9
  localparam logic [15:0] HOLD_EXP [NL] = '{16'h4200, 16'h4500, 16'h4700, 16'h4880, 16'h4980,
                                            16'h4A80, 16'h4B80, 16'h4C40, 16'h4CC0};
  // NaN, +Inf, max normal, subnormal, 1+ulp, 1.0, -2.0, 1.5 (tie), -Inf; weight 1+ulp
  localparam logic [15:0] SPEC_IN  [NL] = '{16'h7E01, 16'h7C00, 16'h7BFF, 16'h0001, 16'h3C01,
                                            16'h3C00, 16'hC000, 16'h3E00, 16'hFC00};
  localparam logic [15:0] SPEC_EXP [NL] = '{16'h7E00, 16'h7C00, 16'h7C00, 16'h0000, 16'h3C02,
                                            16'h3C01, 16'hC001, 16'h3E02, 16'hFC00};
  localparam logic [15:0] SPEC_RLU [NL] = '{16'h7E00, 16'h7C00, 16'h7C00, 16'h0000, 16'h3C02,
                                            16'h3C01, 16'h0000, 16'h3E02, 16'h0000};

  task automatic check_bit(input string name, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic check_vec(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic vec_t splat(input logic [15:0] v);
    vec_t r;
    for (int i = 0; i < NL; i++) r[i] = v;
    return r;
  endfunction

  function automatic vec_t from_tab(input logic [15:0] t [NL]);
    vec_t r;
    for (int i = 0; i < NL; i++) r[i] = t[i];
    return r;
  endfunction

  // Scoreboard monitor: one comparison per output handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_output: got %h, expected no output", out_data);
        end else begin
          check_vec("tile_result", out_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1);
  end

  // All drivers below start and end at posedge+1.
  task automatic start_tile(input int k, input int c, input logic [15:0] bias, input logic relu);
    cfg_kernel_size = KSW'(k);
    cfg_channels    = CHW'(c);
    cfg_bias        = bias;
    cfg_relu        = relu;
    cfg_start       = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic drive_beats(input int n, input vec_t d, input logic [15:0] w, input bit gap);
    for (int b = 0; b < n; b++) begin
      int t = 0;
      in_valid  = 1'b1;
      in_data   = d;
      in_weight = w;
      @(negedge clk);
      while (!in_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        n_vec++;
        n_bad++;
        $display("FAIL beat_ready_timeout: in_ready 0, expected 1");
      end
      @(posedge clk); #1;
      if (gap && b < n - 1) begin
        // Poison the bus during the stall: it must not be absorbed.
        in_valid  = 1'b0;
        in_data   = '1;
        in_weight = 16'h3C00;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_drain_timeout: busy 1, expected 0", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_tile(input string name, input int k, input int c, input logic [15:0] bias,
                          input logic relu, input vec_t d, input logic [15:0] w, input bit gap,
                          input vec_t expv);
    exp_q.push_back(expv);
    start_tile(k, c, bias, relu);
    drive_beats(k * k * c, d, w, gap);
    @(negedge clk);
    check_bit({name, "_out_valid_latency"}, out_valid, 1'b1);
    check_bit({name, "_in_ready_done"}, in_ready, 1'b0);
    wait_idle(name);
  endtask

  localparam int ERR_K [3] = '{0, 8, 3};
  localparam int ERR_C [3] = '{1, 1, 0};

  initial begin
    vec_t hold_exp;
    int   t;
    cfg_start = 1'b0; cfg_kernel_size = '0; cfg_channels = '0; cfg_bias = '0; cfg_relu = 1'b0;
    in_valid = 1'b0; in_data = '0; in_weight = '0; out_ready = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_cfg_err", cfg_err, 1'b0);
    check_vec("rst_out_data", out_data, '0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // K=3 C=1: 9 x (1*1) = 9.0
    run_tile("k3c1", 3, 1, 16'h0000, 1'b0, splat(16'h3C00), 16'h3C00, 1'b0, splat(16'h4880));
    // K=3 C=2 with bias 1.0 and stalls between beats: 19.0
    run_tile("k3c2_stall", 3, 2, 16'h3C00, 1'b0, splat(16'h3C00), 16'h3C00, 1'b1, splat(16'h4CC0));
    // K=1: -1.0 + 0.5 = -0.5, then ReLU
    run_tile("k1_neg", 1, 1, 16'hBC00, 1'b0, splat(16'h3800), 16'h3C00, 1'b0, splat(16'hB800));
    run_tile("k1_relu", 1, 1, 16'hBC00, 1'b1, splat(16'h3800), 16'h3C00, 1'b0, splat(16'h0000));
    // Special values and rounding, with and without ReLU
    run_tile("special", 1, 1, 16'h0000, 1'b0, from_tab(SPEC_IN), 16'h3C01, 1'b0, from_tab(SPEC_EXP));
    run_tile("special_relu", 1, 1, 16'h0000, 1'b1, from_tab(SPEC_IN), 16'h3C01, 1'b0, from_tab(SPEC_RLU));

    // DONE held with out_ready low; cfg_start must be ignored throughout.
    hold_exp = from_tab(HOLD_EXP);
    exp_q.push_back(hold_exp);
    out_ready = 1'b0;
    start_tile(1, 1, 16'h3C00, 1'b1);
    drive_beats(1, from_tab(HOLD_IN), 16'h4000, 1'b0);
    @(negedge clk);
    check_bit("hold_out_valid_latency", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      cfg_kernel_size = KSW'(3);
      cfg_channels    = CHW'(1);
      cfg_start       = (i == 2);
      @(negedge clk);
      check_bit("hold_out_valid", out_valid, 1'b1);
      check_vec("hold_out_data", out_data, hold_exp);
      check_bit("hold_in_ready", in_ready, 1'b0);
      check_bit("hold_cfg_err", cfg_err, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    cfg_start = 1'b1;   // same cycle as the output handshake: must be ignored
    @(negedge clk);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    @(negedge clk);
    check_bit("post_hold_busy", busy, 1'b0);
    check_bit("post_hold_out_valid", out_valid, 1'b0);
    check_bit("post_hold_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;

    // Illegal configurations: one-cycle cfg_err each, never busy.
    for (int j = 0; j < 3; j++) begin
      start_tile(ERR_K[j], ERR_C[j], 16'h0000, 1'b0);
      @(negedge clk);
      check_bit("cfg_err_pulse", cfg_err, 1'b1);
      check_bit("cfg_err_busy", busy, 1'b0);
      check_bit("cfg_err_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check_bit("cfg_err_clear", cfg_err, 1'b0);
      check_bit("cfg_err_busy_after", busy, 1'b0);
      @(posedge clk); #1;
    end

    // Reset after 4 of 9 beats: outputs drop at once, next tile is clean.
    start_tile(3, 1, 16'h4000, 1'b0);
    drive_beats(4, splat(16'h4000), 16'h4000, 1'b0);
    rst = 1'b0;
    #1;
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_in_ready", in_ready, 1'b0);
    check_bit("midrst_out_valid", out_valid, 1'b0);
    check_vec("midrst_out_data", out_data, '0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    run_tile("after_rst", 3, 1, 16'h0000, 1'b0, splat(16'h3C00), 16'h3C00, 1'b0, splat(16'h4880));

    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_bit("scoreboard_drained", exp_q.size() == 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
